// File: rtl/seq_muldiv.sv
// seq_muldiv: sequential unsigned multiplier / restoring divider.
// One shift-add or restore step per CALC cycle. A trailing CALC cycle with
// counter == WIDTH does no arithmetic and moves to DONE, so the latency
// from Run to Ready is WIDTH+1 clocks.
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Ready,
  output logic             DivZero
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_b;      // latched B; latched A lives in Lo
  logic             r_mode;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_ready, r_dz;

  logic             w_accept, w_divz, w_last;
  logic [WIDTH:0]   w_add, w_msum;
  logic [WIDTH-1:0] w_shi;
  logic [WIDTH+1:0] w_trial;

  assign w_accept = Run && (r_state != CALC);
  assign w_divz   = w_accept && Mode && (B == '0);
  assign w_last   = (r_cnt == CW'(WIDTH));

  // Multiply step: optionally add multiplicand into the upper half.
  assign w_add  = {1'b0, r_hi} + {1'b0, r_b};
  assign w_msum = r_lo[0] ? w_add : {1'b0, r_hi};

  // Divide step: shift {Hi,Lo} left, trial-subtract with the shifted-out bit.
  assign w_shi   = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_trial = {1'b0, r_hi[WIDTH-1], w_shi} - {2'b00, r_b};

  // State register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (w_accept) w_next = w_divz ? DONE : CALC;
      CALC:       if (w_last)   w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  // Datapath, counter and result flags.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_cnt   <= '0;
      r_b     <= '0;
      r_mode  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_ready <= 1'b0;
      r_dz    <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_b    <= B;
      r_mode <= Mode;
      if (w_divz) begin
        r_hi    <= A;
        r_lo    <= '1;
        r_ready <= 1'b1;
        r_dz    <= 1'b1;
      end else begin
        r_hi    <= '0;
        r_lo    <= A;
        r_ready <= 1'b0;
        r_dz    <= 1'b0;
      end
    end else if (r_state == CALC) begin
      if (w_last) begin
        r_ready <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        if (!r_mode) begin
          r_hi <= w_msum[WIDTH:1];
          r_lo <= {w_msum[0], r_lo[WIDTH-1:1]};
        end else if (!w_trial[WIDTH+1]) begin
          r_hi <= w_trial[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b1};
        end else begin
          r_hi <= w_shi;
          r_lo <= {r_lo[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  assign Hi      = r_hi;
  assign Lo      = r_lo;
  assign Busy    = (r_state == CALC);
  assign Ready   = r_ready;
  assign DivZero = r_dz;
endmodule

// File: tb/tb_seq_muldiv.sv
// Directed bench for seq_muldiv at WIDTH=32 and WIDTH=8.
module tb_seq_muldiv;
  logic clk = 1'b0;
  logic Reset = 1'b1;

  logic        Run, Mode;
  logic [31:0] A, B, Hi, Lo;
  logic        Busy, Ready, DivZero;

  logic        Run8, Mode8;
  logic [7:0]  A8, B8, Hi8, Lo8;
  logic        Busy8, Ready8, DivZero8;

  int npass = 0;
  int ntot  = 0;

  seq_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .Reset(Reset), .Run(Run), .Mode(Mode), .A(A), .B(B),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Ready(Ready), .DivZero(DivZero)
  );

  seq_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .Reset(Reset), .Run(Run8), .Mode(Mode8), .A(A8), .B(B8),
    .Hi(Hi8), .Lo(Lo8), .Busy(Busy8), .Ready(Ready8), .DivZero(DivZero8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Present a request at negedge; it is accepted on the following posedge.
  task automatic go32(input logic m, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Run = 1'b1; Mode = m; A = a; B = b;
    @(posedge clk); #1;
    Run = 1'b0; Mode = ~m; A = $urandom; B = $urandom;  // must not matter
  endtask

  // Full 32-bit operation with exact latency and final-value checks.
  task automatic op32(input string tag, input logic m, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    go32(m, a, b);
    chk({tag, ".busy"}, 64'(Busy), 64'd1);
    repeat (32) @(posedge clk);
    #1 chk({tag, ".notyet"}, 64'(Ready), 64'd0);
    @(posedge clk); #1;
    chk({tag, ".ready"}, 64'(Ready), 64'd1);
    chk({tag, ".busy0"}, 64'(Busy), 64'd0);
    chk({tag, ".hi"}, 64'(Hi), 64'(ehi));
    chk({tag, ".lo"}, 64'(Lo), 64'(elo));
    chk({tag, ".dz"}, 64'(DivZero), 64'd0);
  endtask

  task automatic op8(input string tag, input logic m, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] ehi, input logic [7:0] elo);
    @(negedge clk);
    Run8 = 1'b1; Mode8 = m; A8 = a; B8 = b;
    @(posedge clk); #1;
    Run8 = 1'b0; A8 = 8'h5A; B8 = 8'hA5;
    repeat (8) @(posedge clk);
    #1 chk({tag, ".notyet"}, 64'(Ready8), 64'd0);
    @(posedge clk); #1;
    chk({tag, ".ready"}, 64'(Ready8), 64'd1);
    chk({tag, ".hi"}, 64'(Hi8), 64'(ehi));
    chk({tag, ".lo"}, 64'(Lo8), 64'(elo));
  endtask

  initial begin
    Run = 0; Mode = 0; A = 0; B = 0;
    Run8 = 0; Mode8 = 0; A8 = 0; B8 = 0;

    // Reset state
    #3;
    chk("rst.hi", 64'(Hi), 64'd0);
    chk("rst.lo", 64'(Lo), 64'd0);
    chk("rst.flags", 64'({Busy, Ready, DivZero}), 64'd0);
    @(negedge clk); Reset = 1'b0;

    // Max operands multiply and ordinary divides
    op32("mulmax", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    op32("div100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
    op32("mulshift", 1'b0, 32'h12345678, 32'h10, 32'h1, 32'h23456780);
    op32("divsmall", 1'b1, 32'd5, 32'd9, 32'd5, 32'd0);
    op32("divmax", 1'b1, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFF);

    // Result holds in DONE
    repeat (3) @(posedge clk);
    #1 chk("hold.ready", 64'(Ready), 64'd1);
    chk("hold.lo", 64'(Lo), 64'hFFFFFFFF);

    // Divide by zero: DONE one clock after accept, no CALC
    go32(1'b1, 32'h1234, 32'h0);
    chk("dz.ready", 64'(Ready), 64'd1);
    chk("dz.flag", 64'(DivZero), 64'd1);
    chk("dz.busy", 64'(Busy), 64'd0);
    chk("dz.lo", 64'(Lo), 64'hFFFFFFFF);
    chk("dz.hi", 64'(Hi), 64'h1234);

    // Reset mid-calculation, Run ignored during reset
    go32(1'b0, 32'hDEADBEEF, 32'h77);
    repeat (10) @(posedge clk);
    #2 Reset = 1'b1;
    #1;
    chk("midrst.hi", 64'(Hi), 64'd0);
    chk("midrst.lo", 64'(Lo), 64'd0);
    chk("midrst.flags", 64'({Busy, Ready, DivZero}), 64'd0);
    @(negedge clk); Run = 1'b1; Mode = 1'b0; A = 32'd9; B = 32'd9;
    @(posedge clk); #1;
    chk("rstrun.busy", 64'(Busy), 64'd0);
    Run = 1'b0; Reset = 1'b0;
    op32("afterrst", 1'b0, 32'd3, 32'd5, 32'd0, 32'd15);

    // Run during CALC ignored, then back-to-back from DONE
    go32(1'b0, 32'd6, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk); Run = 1'b1; Mode = 1'b1; A = 32'd1000; B = 32'd3;
    @(negedge clk); Run = 1'b0;
    repeat (26) @(posedge clk);
    #1 chk("ign.notyet", 64'(Ready), 64'd0);
    @(posedge clk); #1;
    chk("ign.ready", 64'(Ready), 64'd1);
    chk("ign.hi", 64'(Hi), 64'd0);
    chk("ign.lo", 64'(Lo), 64'd42);
    op32("b2b", 1'b1, 32'd1000, 32'd33, 32'd10, 32'd30);

    // WIDTH=8 instance
    op8("w8mul", 1'b0, 8'hFF, 8'h02, 8'h01, 8'hFE);
    op8("w8div", 1'b1, 8'hFF, 8'h10, 8'h0F, 8'h0F);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
